// File: rtl/weight_preload_sequencer.sv
// Weight preload sequencer: turns a valid/ready weight stream into row-major
// mesh preload writes, then signals done (and optionally start) once the last write lands.
module weight_preload_sequencer #(
    parameter int DW         = 8,
    parameter int ROWS       = 16,
    parameter int COLS       = 24,
    parameter int ROW_W      = 4,
    parameter int COL_W      = 5,
    parameter bit AUTO_START = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_req,
    input  logic                   abort,
    input  logic                   s_valid,
    input  logic [DW-1:0]          s_data,
    output logic                   s_ready,
    output logic                   preload_valid,
    output logic [ROW_W+COL_W-1:0] preload_addr,
    output logic [DW-1:0]          preload_data,
    output logic                   start,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, FIRE} state_t;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    state_t                   state_q, state_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic [COL_W-1:0]         col_q, col_d;
    logic                     pv_q;
    logic [ROW_W+COL_W-1:0]   addr_q;
    logic [DW-1:0]            data_q;
    logic                     start_q, done_q;
    logic                     xfer;
    logic                     last_beat;

    // Ready is decoded from state alone so there is no s_valid -> s_ready path.
    assign s_ready   = (state_q == LOAD);
    assign xfer      = s_ready & s_valid;
    assign last_beat = (row_q == ROW_LAST) && (col_q == COL_LAST);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            IDLE: begin
                if (load_req) begin
                    state_d = LOAD;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            LOAD: begin
                if (xfer) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
                // Abort outranks completion; the beat taken this cycle is still written.
                if (abort) begin
                    state_d = IDLE;
                    row_d   = '0;
                    col_d   = '0;
                end else if (xfer && last_beat) begin
                    state_d = FLUSH;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            FLUSH:   state_d = FIRE;
            FIRE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            pv_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            pv_q    <= xfer;
            if (xfer) begin
                addr_q <= {row_q, col_q};
                data_q <= s_data;
            end
            done_q  <= (state_d == FIRE);
            start_q <= AUTO_START && (state_d == FIRE);
        end
    end

    assign preload_valid = pv_q;
    assign preload_addr  = addr_q;
    assign preload_data  = data_q;
    assign start         = start_q;
    assign done          = done_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: doc/weight_preload_sequencer.md
Name: weight_preload_sequencer

Overview:
- Drives the mesh weight-preload write interface (preload_valid / preload_addr / preload_data) from a valid/ready byte stream of weights.
- Generates row-major {row,col} addresses, then pulses start to kick the array FSM once the last weight write has landed.
- Sits upstream of the accelerator top, between the host/DMA weight stream and the preload port.

Parameters:
- DW, 8, weight width in bits.
- ROWS, 16, mesh rows.
- COLS, 24, mesh columns (need not be a power of 2).
- ROW_W, 4, row index width in preload_addr.
- COL_W, 5, column index width in preload_addr.
- AUTO_START, 1, when 1 pulse start after the load completes; when 0 never assert start.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- load_req  input  1  pulse: begin a full ROWS*COLS weight load
- abort  input  1  cancel an in-progress load
- s_valid  input  1  weight stream beat valid
- s_data  input  DW  signed weight
- s_ready  output  1  sequencer accepts a beat
- preload_valid  output  1  weight write strobe to mesh
- preload_addr  output  ROW_W+COL_W  {row[ROW_W-1:0], col[COL_W-1:0]}
- preload_data  output  DW  signed weight to mesh
- start  output  1  one-cycle compute kick to the array FSM
- busy  output  1  state != IDLE
- done  output  1  one-cycle load-complete pulse

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst. On rst, state=IDLE, row=col=0, and all outputs are 0 (s_ready, preload_valid, preload_addr, preload_data, start, busy, done).
- States: IDLE, LOAD, FLUSH, FIRE.
- IDLE:
  - s_ready=0.
  - load_req=1 -> LOAD with row=col=0.
  - abort is ignored.
- LOAD:
  - s_ready=1, decoded from state only; no combinational path from s_valid.
  - A beat transfers when s_valid & s_ready.
  - On a transfer, in the next cycle: preload_valid=1, preload_addr={row,col} of that beat, preload_data=s_data. Latency is exactly 1 cycle.
  - With no transfer, preload_valid=0 next cycle and addr/data hold their last values.
  - Counter advance per transfer: col+1. When col==COLS-1, col wraps to 0 and row increments. col never reaches COLS, so 24..31 are never issued.
  - A transfer at (ROWS-1, COLS-1) -> FLUSH. s_ready=0 from the next cycle.
  - abort=1 in LOAD -> IDLE next cycle, no start/done, row=col=0. A beat accepted in the abort cycle is still written (preload_valid next cycle).
  - If abort and the final transfer occur in the same cycle, abort wins: go to IDLE, and the last write is still issued.
  - load_req in LOAD, FLUSH or FIRE is ignored.
- FLUSH:
  - The last preload_valid is high this cycle; s_ready=0.
  - Unconditionally -> FIRE. abort is ignored.
- FIRE:
  - done=1 for one cycle. start=1 for one cycle if AUTO_START=1.
  - start is therefore asserted exactly 1 cycle after the final preload_valid, never coincident with it.
  - -> IDLE.
- busy=1 in LOAD, FLUSH and FIRE.
- A new load_req is accepted in the cycle after FIRE, i.e. the first IDLE cycle.
- Total writes per load = ROWS*COLS = 384. Addresses are strictly row-major and unique.
- start, done and preload_valid are registered outputs.

Test Plan:
- Reset then idle: hold rst 2 cycles, s_valid=1 -> s_ready=0, preload_valid=0, start=0, busy=0 throughout.
- Full back-to-back load:
  - Stimulus: load_req, then s_valid=1 continuously with data = beat index mod 128.
  - Required: 384 preload_valid pulses, the first with addr 0x000, data 0.
  - Beat 24 -> addr {1,0} = 0x020; last beat -> addr {15,23} = 0x1F7.
  - start and done are high 1 cycle after the last preload_valid; busy drops the next cycle.
- Bubbled stream: random s_valid gaps (~50%) -> same 384-address sequence, with preload_valid only on the cycle after each accepted beat; start fires exactly once.
- Abort:
  - Stimulus: abort asserted after 100 accepted beats, with s_valid=1 in the abort cycle.
  - Required: the 101st write is issued, then s_ready=0, no start/done.
  - A following load_req restarts at addr 0x000.
- Simultaneous abort with final beat: abort wins; write to 0x1F7 is issued, no start/done, state returns to IDLE.
- Mid-load reset and AUTO_START=0:
  - rst asserted at beat 200 -> all outputs 0 next cycle; the next load restarts at 0x000.
  - With AUTO_START=0 a full load gives done=1 and start never asserted.
